// File: rtl/reg_wb_queue.sv
// Writeback queue in front of the register file write port: in-order FIFO
// with drain on grant and youngest-match forwarding for two read addresses.
module reg_wb_queue #(
    parameter  int DEPTH = 4,
    parameter  int DW    = 32,
    parameter  int AW    = 5,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = ((PW + 1) > AW) ? (PW + 1) : AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    input  logic          rf_grant,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    input  logic [AW-1:0] fw_raddr1,
    input  logic [AW-1:0] fw_raddr2,
    output logic          fw_hit1,
    output logic          fw_hit2,
    output logic [DW-1:0] fw_data1,
    output logic [DW-1:0] fw_data2,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic             w_push;
    logic             w_pop;
    logic [PW-1:0]    w_idx;

    assign empty    = (r_count == '0);
    assign in_ready = (r_count != CW'(DEPTH));
    // Writes to x0 complete the handshake but are dropped here.
    assign w_push   = in_valid && in_ready && (in_addr != '0);
    assign rf_we    = !empty && rf_grant;
    assign w_pop    = rf_we;
    assign rf_waddr = empty ? '0 : r_addr[r_head];
    assign rf_wdata = empty ? '0 : r_data[r_head];
    assign count    = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_pop) begin
                r_head          <= r_head + 1'b1;
                r_valid[r_head] <= 1'b0;
            end
            if (w_push) begin
                r_tail          <= r_tail + 1'b1;
                r_valid[r_tail] <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= in_addr;
            r_data[r_tail] <= in_data;
        end
    end

    // Scan oldest to youngest so the last match found is the youngest.
    always_comb begin
        fw_hit1  = 1'b0;
        fw_hit2  = 1'b0;
        fw_data1 = '0;
        fw_data2 = '0;
        w_idx    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (r_valid[w_idx] && (fw_raddr1 != '0) && (r_addr[w_idx] == fw_raddr1)) begin
                fw_hit1  = 1'b1;
                fw_data1 = r_data[w_idx];
            end
            if (r_valid[w_idx] && (fw_raddr2 != '0) && (r_addr[w_idx] == fw_raddr2)) begin
                fw_hit2  = 1'b1;
                fw_data2 = r_data[w_idx];
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue: reset, single write, fill/drain, forwarding,
// x0 writes, asynchronous reset mid-operation and back-to-back streaming.
module tb_reg_wb_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        rf_grant;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  fw_raddr1;
    logic [4:0]  fw_raddr2;
    logic        fw_hit1;
    logic        fw_hit2;
    logic [31:0] fw_data1;
    logic [31:0] fw_data2;
    logic [4:0]  count;
    logic        empty;

    int n_vec = 0;
    int n_err = 0;

    reg_wb_queue #(.DEPTH(4), .DW(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .rf_grant(rf_grant), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fw_raddr1(fw_raddr1), .fw_raddr2(fw_raddr2),
        .fw_hit1(fw_hit1), .fw_hit2(fw_hit2), .fw_data1(fw_data1), .fw_data2(fw_data2),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        rf_grant = 1'b0; fw_raddr1 = 5'd5; fw_raddr2 = 5'd0;
        tick(); tick();
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_we got %0h exp 0", rf_we); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %0h exp 1", empty); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0h exp 1", in_ready); end
        n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
        n_vec++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin n_err++; $display("FAIL reset_wport got %0h/%0h exp 0/0", rf_waddr, rf_wdata); end
        n_vec++; if (fw_hit1 !== 1'b0 || fw_hit2 !== 1'b0 || fw_data1 !== 32'd0) begin n_err++; $display("FAIL reset_fw got %0h%0h/%0h exp 00/0", fw_hit1, fw_hit2, fw_data1); end
        rst_n = 1'b1;
        tick();
        n_vec++; if (rf_we !== 1'b0 || count !== 5'd0) begin n_err++; $display("FAIL idle got we=%0h cnt=%0d exp 0/0", rf_we, count); end
    endtask

    task automatic test_single();
        rf_grant = 1'b1; fw_raddr1 = 5'd3;
        in_valid = 1'b1; in_addr = 5'd3; in_data = 32'hDEADBEEF;
        #1;
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL single_nobypass got %0h exp 0", rf_we); end
        n_vec++; if (fw_hit1 !== 1'b0) begin n_err++; $display("FAIL single_fw_incoming got %0h exp 0", fw_hit1); end
        tick();
        in_valid = 1'b0;
        n_vec++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL single_we got %0h exp 1", rf_we); end
        n_vec++; if (rf_waddr !== 5'd3) begin n_err++; $display("FAIL single_waddr got %0d exp 3", rf_waddr); end
        n_vec++; if (rf_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_wdata got %0h exp deadbeef", rf_wdata); end
        n_vec++; if (fw_hit1 !== 1'b1 || fw_data1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_fw_head got %0h/%0h exp 1/deadbeef", fw_hit1, fw_data1); end
        tick();
        n_vec++; if (empty !== 1'b1 || rf_we !== 1'b0) begin n_err++; $display("FAIL single_drained got e=%0h we=%0h exp 1/0", empty, rf_we); end
    endtask

    task automatic test_fill();
        rf_grant = 1'b0;
        for (int k = 1; k <= 4; k++) push(5'(k), 32'(k * 32'h11));
        n_vec++; if (count !== 5'd4) begin n_err++; $display("FAIL fill_count got %0d exp 4", count); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready got %0h exp 0", in_ready); end
        push(5'd5, 32'h55);
        n_vec++; if (count !== 5'd4) begin n_err++; $display("FAIL fill_5th got %0d exp 4", count); end
        n_vec++; if (rf_we !== 1'b0 || rf_waddr !== 5'd1) begin n_err++; $display("FAIL fill_hold got we=%0h a=%0d exp 0/1", rf_we, rf_waddr); end
        rf_grant = 1'b1;
        #1;
        for (int k = 1; k <= 4; k++) begin
            n_vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'(k) || rf_wdata !== 32'(k * 32'h11)) begin
                n_err++; $display("FAIL drain_%0d got we=%0h a=%0d d=%0h exp 1/%0d/%0h", k, rf_we, rf_waddr, rf_wdata, k, k * 32'h11);
            end
            tick();
            if (k == 1) begin
                n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL drain_ready got %0h exp 1", in_ready); end
            end
        end
        n_vec++; if (empty !== 1'b1 || count !== 5'd0) begin n_err++; $display("FAIL drain_empty got e=%0h c=%0d exp 1/0", empty, count); end
    endtask

    task automatic test_forward();
        rf_grant = 1'b0;
        push(5'd7, 32'hA);
        push(5'd7, 32'hB);
        fw_raddr1 = 5'd7; fw_raddr2 = 5'd0;
        in_valid = 1'b1; in_addr = 5'd9; in_data = 32'h99;
        #1;
        n_vec++; if (fw_hit1 !== 1'b1 || fw_data1 !== 32'hB) begin n_err++; $display("FAIL fw_young got %0h/%0h exp 1/b", fw_hit1, fw_data1); end
        n_vec++; if (fw_hit2 !== 1'b0 || fw_data2 !== 32'd0) begin n_err++; $display("FAIL fw_x0 got %0h/%0h exp 0/0", fw_hit2, fw_data2); end
        fw_raddr2 = 5'd9;
        #1;
        n_vec++; if (fw_hit2 !== 1'b0) begin n_err++; $display("FAIL fw_pending got %0h exp 0", fw_hit2); end
        in_valid = 1'b0;
        rf_grant = 1'b1;
        tick();
        n_vec++; if (fw_hit1 !== 1'b1 || fw_data1 !== 32'hB || rf_wdata !== 32'hB) begin n_err++; $display("FAIL fw_after1 got %0h/%0h w=%0h exp 1/b/b", fw_hit1, fw_data1, rf_wdata); end
        tick();
        n_vec++; if (fw_hit1 !== 1'b0 || fw_data1 !== 32'd0) begin n_err++; $display("FAIL fw_drained got %0h/%0h exp 0/0", fw_hit1, fw_data1); end
    endtask

    task automatic test_zero();
        rf_grant = 1'b1;
        in_valid = 1'b1; in_addr = 5'd0; in_data = 32'hFFFFFFFF;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready got %0h exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_vec++; if (count !== 5'd0 || rf_we !== 1'b0) begin n_err++; $display("FAIL x0_drop got c=%0d we=%0h exp 0/0", count, rf_we); end
        tick();
        n_vec++; if (rf_we !== 1'b0 || empty !== 1'b1) begin n_err++; $display("FAIL x0_later got we=%0h e=%0h exp 0/1", rf_we, empty); end
    endtask

    task automatic test_reset_mid();
        rf_grant = 1'b0;
        push(5'd12, 32'h120);
        push(5'd13, 32'h130);
        push(5'd14, 32'h140);
        fw_raddr1 = 5'd13;
        #1;
        n_vec++; if (count !== 5'd3 || fw_hit1 !== 1'b1) begin n_err++; $display("FAIL mid_pre got c=%0d h=%0h exp 3/1", count, fw_hit1); end
        #1;
        rf_grant = 1'b1;
        rst_n = 1'b0;
        #1;
        n_vec++; if (count !== 5'd0 || empty !== 1'b1 || in_ready !== 1'b1) begin n_err++; $display("FAIL mid_async got c=%0d e=%0h r=%0h exp 0/1/1", count, empty, in_ready); end
        n_vec++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin n_err++; $display("FAIL mid_wport got %0h/%0h/%0h exp 0/0/0", rf_we, rf_waddr, rf_wdata); end
        n_vec++; if (fw_hit1 !== 1'b0 || fw_data1 !== 32'd0) begin n_err++; $display("FAIL mid_fw got %0h/%0h exp 0/0", fw_hit1, fw_data1); end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++; if (rf_we !== 1'b0 || count !== 5'd0) begin n_err++; $display("FAIL mid_post_%0d got we=%0h c=%0d exp 0/0", k, rf_we, count); end
        end
    endtask

    task automatic test_back_to_back();
        rf_grant = 1'b1;
        push(5'd10, 32'h100);
        for (int k = 1; k <= 10; k++) begin
            in_valid = 1'b1; in_addr = 5'(10 + k); in_data = 32'(32'h100 + k);
            #1;
            n_vec++; if (count !== 5'd1 || rf_we !== 1'b1 || rf_waddr !== 5'(9 + k) || rf_wdata !== 32'(32'hFF + k)) begin
                n_err++; $display("FAIL b2b_%0d got c=%0d we=%0h a=%0d d=%0h exp 1/1/%0d/%0h", k, count, rf_we, rf_waddr, rf_wdata, 9 + k, 32'hFF + k);
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'd20 || rf_wdata !== 32'h10A) begin n_err++; $display("FAIL b2b_last got we=%0h a=%0d d=%0h exp 1/20/10a", rf_we, rf_waddr, rf_wdata); end
        tick();
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty got %0h exp 1", empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_forward();
        test_zero();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
